// File: rtl/adder4_seq_ctrl.sv
// WIDTH-bit add built from one shared 4-bit adder slice, LS nibble first, carry fed back; `ADDER4_SEQ_CTRL_SUB_EN adds a 'sub' input for a - b.
// Latency: done pulses NIB cycles after the accepting edge; one op per NIB+2 cycles.
// Backpressure: start is accepted only while ready=1; requests at other times are dropped, not queued.
module adder4_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER4_SEQ_CTRL_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic [NIB-1:0][3:0] a_q;
    logic [NIB-1:0][3:0] b_q;
    logic [NIB-1:0][3:0] acc_q;
    logic [NIB-1:0][3:0] acc_nxt;
    logic [IDXW-1:0]     idx_q;
    logic                carry_q;

    logic                accept;
    logic                last_nib;
    logic [WIDTH-1:0]    b_load;
    logic                carry_load;

    assign accept   = (state_q == ST_IDLE) && start;
    assign last_nib = (idx_q == IDX_LAST);

    // Subtraction is a + ~b + 1, so only the loaded operand and initial carry differ.
`ifdef ADDER4_SEQ_CTRL_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: if (start)    state_nxt = ST_RUN;
            ST_RUN:  if (last_nib) state_nxt = ST_DONE;
            ST_DONE:               state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: the shared slice sees all-zero inputs whenever this block is not using it.
    always_comb begin
        ready   = 1'b0;
        done    = 1'b0;
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        unique case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_RUN: begin
                add_a   = a_q[idx_q];
                add_b   = b_q[idx_q];
                add_cin = carry_q;
            end
            ST_DONE: done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_comb begin
        acc_nxt        = acc_q;
        acc_nxt[idx_q] = add_s;
    end

    // Datapath registers; s/cout only move on the final nibble so they hold between ops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_load;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= carry_load;
        end else if (state_q == ST_RUN) begin
            acc_q   <= acc_nxt;
            carry_q <= add_cout;
            idx_q   <= idx_q + 1'b1;
            if (last_nib) begin
                s    <= acc_nxt;
                cout <= add_cout;
            end
        end
    end

endmodule
